// File: rtl/detect_double_clap_if.sv
// Energy-frame stream handshake between the audio energy stage and the
// double-clap detector.
interface detect_double_clap_if #(
  parameter int ENERGY_WIDTH = 32
);
  logic [ENERGY_WIDTH-1:0] energy_data;
  logic                    energy_valid;
  logic                    energy_ready;

  modport master (
    output energy_data,
    output energy_valid,
    input  energy_ready
  );

  modport slave (
    input  energy_data,
    input  energy_valid,
    output energy_ready
  );
endinterface

// File: rtl/detect_double_clap.sv
// Double-clap detector: classifies energy frames with hysteresis thresholds,
// tracks clap / gap / clap timing in frames and toggles the light on success.
module detect_double_clap #(
  parameter int unsigned ENERGY_WIDTH   = 32,
  parameter int unsigned THRESHOLD_HIGH = 1000000,
  parameter int unsigned THRESHOLD_LOW  = 250000,
  parameter int unsigned MIN_GAP        = 2,
  parameter int unsigned MAX_GAP        = 40,
  parameter int unsigned MAX_CLAP_LEN   = 8,
  parameter int unsigned LOCKOUT_FRAMES = 16
) (
  input  logic                        clock,
  input  logic                        resetn,
  detect_double_clap_if.slave         energy,
  output logic                        light,
  output logic                        double_clap,
  output logic [2:0]                  clap_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLAP1   = 3'd1,
    GAP     = 3'd2,
    CLAP2   = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  localparam int unsigned CNT_MAX_A = (MAX_GAP > MAX_CLAP_LEN) ? MAX_GAP : MAX_CLAP_LEN;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCKOUT_FRAMES) ? CNT_MAX_A : LOCKOUT_FRAMES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [ENERGY_WIDTH-1:0] TH_HIGH = ENERGY_WIDTH'(THRESHOLD_HIGH);
  localparam logic [ENERGY_WIDTH-1:0] TH_LOW  = ENERGY_WIDTH'(THRESHOLD_LOW);

  // n is one bit wider than the counter so cnt+1 can never wrap.
  localparam logic [CNT_W:0]   N_MIN_GAP  = (CNT_W+1)'(MIN_GAP);
  localparam logic [CNT_W:0]   N_MAX_GAP  = (CNT_W+1)'(MAX_GAP);
  localparam logic [CNT_W:0]   N_MAX_CLAP = (CNT_W+1)'(MAX_CLAP_LEN);
  localparam logic [CNT_W:0]   N_LOCK     = (CNT_W+1)'(LOCKOUT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LOCK   = CNT_W'(LOCKOUT_FRAMES);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [ENERGY_WIDTH-1:0] frame_buf_q;
  logic                    ready_q;
  logic                    eval_q;
  logic                    light_q, light_d;
  logic                    double_clap_q, double_clap_d;

  logic                    accept;
  logic                    is_high;
  logic                    is_low;
  logic [CNT_W:0]          n;

  assign accept = energy.energy_valid & ready_q;

  // Handshake and frame latch. Ready drops on the accept edge and comes back
  // on the evaluate edge, so it is a pure register with no path from valid.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_q     <= 1'b0;
      eval_q      <= 1'b0;
      frame_buf_q <= '0;
    end else begin
      ready_q <= ~accept;
      eval_q  <= accept;
      if (accept) begin
        frame_buf_q <= energy.energy_data;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      light_q       <= 1'b0;
      double_clap_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      light_q       <= light_d;
      double_clap_q <= double_clap_d;
    end
  end

  assign is_high = (frame_buf_q >= TH_HIGH);
  assign is_low  = (frame_buf_q <  TH_LOW);
  assign n       = {1'b0, frame_cnt_q} + 1'b1;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    light_d       = light_q;
    double_clap_d = 1'b0;

    if (eval_q) begin
      unique case (state_q)
        IDLE: begin
          if (is_high) begin
            state_d     = CLAP1;
            frame_cnt_d = '0;
          end
        end

        CLAP1: begin
          if (is_low) begin
            state_d     = GAP;
            frame_cnt_d = '0;
          end else if (n == N_MAX_CLAP) begin
            state_d     = LOCKOUT;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = n[CNT_W-1:0];
          end
        end

        GAP: begin
          if (is_high) begin
            state_d     = (n > N_MIN_GAP) ? CLAP2 : LOCKOUT;
            frame_cnt_d = '0;
          end else if (n == N_MAX_GAP) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = n[CNT_W-1:0];
          end
        end

        CLAP2: begin
          if (is_low) begin
            state_d       = LOCKOUT;
            frame_cnt_d   = '0;
            light_d       = ~light_q;
            double_clap_d = 1'b1;
          end else if (n == N_MAX_CLAP) begin
            state_d     = LOCKOUT;
            frame_cnt_d = '0;
          end else begin
            frame_cnt_d = n[CNT_W-1:0];
          end
        end

        LOCKOUT: begin
          // Counter saturates so sustained noise can hold lockout forever.
          if (is_low && (n >= N_LOCK)) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
          end else if (n >= N_LOCK) begin
            frame_cnt_d = CNT_LOCK;
          end else begin
            frame_cnt_d = n[CNT_W-1:0];
          end
        end

        default: begin
          state_d     = IDLE;
          frame_cnt_d = '0;
        end
      endcase
    end
  end

  assign energy.energy_ready = ready_q;
  assign light               = light_q;
  assign double_clap         = double_clap_q;
  assign clap_state          = state_q;

endmodule

// File: tb/tb_detect_double_clap.sv
// Directed, table-driven bench for detect_double_clap with hand-written
// sequences for pulse width, backpressure and asynchronous reset.
module tb_detect_double_clap;

  localparam logic [31:0] HI  = 32'd2000000;
  localparam logic [31:0] MID = 32'd500000;
  localparam logic [31:0] LO  = 32'd0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  exp_state;
    logic        exp_light;
    logic        exp_pulse;
  } vec_t;

  logic clock = 1'b0;
  logic resetn;
  logic light;
  logic double_clap;
  logic [2:0] clap_state;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  detect_double_clap_if #(.ENERGY_WIDTH(32)) eif ();

  detect_double_clap dut (
    .clock       (clock),
    .resetn      (resetn),
    .energy      (eif.slave),
    .light       (light),
    .double_clap (double_clap),
    .clap_state  (clap_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void add(input logic [31:0] d, input logic [2:0] st, input logic l, input logic p);
    vec_t v;
    v.data = d; v.exp_state = st; v.exp_light = l; v.exp_pulse = p;
    vecs.push_back(v);
  endfunction

  // Called at a negedge; returns at the negedge after the evaluate edge.
  task automatic send_frame(input logic [31:0] d);
    int waited = 0;
    while (eif.energy_ready !== 1'b1 && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    check("ready_before_frame", 32'(eif.energy_ready), 32'd1);
    eif.energy_valid = 1'b1;
    eif.energy_data  = d;
    @(negedge clock);
    eif.energy_valid = 1'b0;
    check("ready_low_after_accept", 32'(eif.energy_ready), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    // Valid double clap, then lockout drained by 16 lows.
    add(LO, 3'd0, 1'b0, 1'b0);
    add(HI, 3'd1, 1'b0, 1'b0);
    add(HI, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) add(LO, 3'd2, 1'b0, 1'b0);
    add(HI, 3'd3, 1'b0, 1'b0);
    add(LO, 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) add(LO, 3'd4, 1'b1, 1'b0);
    add(LO, 3'd0, 1'b1, 1'b0);
    // Second double clap toggles light back; sustained noise holds lockout.
    add(HI, 3'd1, 1'b1, 1'b0);
    add(LO, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(LO, 3'd2, 1'b1, 1'b0);
    add(HI, 3'd3, 1'b1, 1'b0);
    add(LO, 3'd4, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) add(HI, 3'd4, 1'b0, 1'b0);
    add(LO, 3'd0, 1'b0, 1'b0);
    // Too-soon second clap.
    add(HI, 3'd1, 1'b0, 1'b0);
    add(LO, 3'd2, 1'b0, 1'b0);
    add(HI, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) add(LO, 3'd4, 1'b0, 1'b0);
    add(LO, 3'd0, 1'b0, 1'b0);
    // Gap timeout on the 40th gap frame, then a fresh clap; mid keeps CLAP1.
    add(HI, 3'd1, 1'b0, 1'b0);
    add(LO, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 39; i++) add(LO, 3'd2, 1'b0, 1'b0);
    add(LO, 3'd0, 1'b0, 1'b0);
    add(HI, 3'd1, 1'b0, 1'b0);
    add(MID, 3'd1, 1'b0, 1'b0);
    add(LO, 3'd2, 1'b0, 1'b0);
    // Second clap too long: 8 non-low frames after entry abort, no toggle.
    add(LO, 3'd2, 1'b0, 1'b0);
    add(LO, 3'd2, 1'b0, 1'b0);
    add(HI, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) add(HI, 3'd3, 1'b0, 1'b0);
    add(HI, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) add(LO, 3'd4, 1'b0, 1'b0);
    add(LO, 3'd0, 1'b0, 1'b0);

    // Reset held with valid asserted.
    resetn = 1'b0;
    eif.energy_valid = 1'b1;
    eif.energy_data  = HI;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(eif.energy_ready), 32'd0);
    check("rst_light", 32'(light), 32'd0);
    check("rst_pulse", 32'(double_clap), 32'd0);
    check("rst_state", 32'(clap_state), 32'd0);

    resetn = 1'b1;
    eif.energy_valid = 1'b0;
    #1;
    check("release_ready_not_yet", 32'(eif.energy_ready), 32'd0);
    @(negedge clock);
    check("release_ready_one_cycle", 32'(eif.energy_ready), 32'd1);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data);
      check($sformatf("vec%0d_state", i), 32'(clap_state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_light", i), 32'(light), 32'(vecs[i].exp_light));
      check($sformatf("vec%0d_pulse", i), 32'(double_clap), 32'(vecs[i].exp_pulse));
    end

    // Pulse is exactly one cycle wide.
    send_frame(HI); send_frame(HI);
    for (int i = 0; i < 4; i++) send_frame(LO);
    send_frame(HI);
    check("dc_clap2", 32'(clap_state), 32'd3);
    send_frame(LO);
    check("dc_pulse_hi", 32'(double_clap), 32'd1);
    check("dc_light_on", 32'(light), 32'd1);
    @(negedge clock);
    check("dc_pulse_one_cycle", 32'(double_clap), 32'd0);
    check("dc_light_held", 32'(light), 32'd1);
    for (int i = 0; i < 16; i++) send_frame(LO);
    check("dc_lockout_exit", 32'(clap_state), 32'd0);

    // Backpressure: valid held high, each frame taken once, in order.
    eif.energy_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("bp%0d_ready1", i), 32'(eif.energy_ready), 32'd1);
      eif.energy_data = HI + 32'(i);
      @(negedge clock);
      check($sformatf("bp%0d_ready0", i), 32'(eif.energy_ready), 32'd0);
      eif.energy_data = LO;
      @(negedge clock);
      check($sformatf("bp%0d_state", i), 32'(clap_state), (i < 8) ? 32'd1 : 32'd4);
    end
    eif.energy_valid = 1'b0;
    check("bp_light", 32'(light), 32'd1);
    for (int i = 0; i < 16; i++) send_frame(LO);
    check("bp_lockout_exit", 32'(clap_state), 32'd0);

    // Asynchronous reset while in CLAP2 with the light on (gap of exactly 3).
    send_frame(HI);
    send_frame(LO);
    send_frame(LO);
    send_frame(LO);
    send_frame(HI);
    check("ar_clap2", 32'(clap_state), 32'd3);
    check("ar_light_before", 32'(light), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("ar_light_cleared", 32'(light), 32'd0);
    check("ar_state_cleared", 32'(clap_state), 32'd0);
    check("ar_ready_cleared", 32'(eif.energy_ready), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
